// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified-memory port logic of the 5-stage core:
// response-owner encoding and the "no bytes written" enable pattern.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } owner_t;

    localparam logic [3:0] WEN_NONE = 4'b0000;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive data wins against a waiting fetch and raises force_i once
// the fetch has lost STARVE_MAX times in a row.
module arb_starve_counter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic force_i
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        // Any fetch win, or fetch no longer waiting, ends the losing streak.
        if (i_gnt || !i_req) begin
            cnt_next = 4'd0;
        end else if (d_gnt && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign force_i = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between fetch and load/store,
// data-first with starvation relief, and steers each read return to its issuer.
module sram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              port_stall
);

    owner_t state_reg;
    owner_t state_next;
    logic   force_i;

    arb_starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt),
        .force_i (force_i)
    );

    // Grants are suppressed for the whole time reset is held.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (i_req && (!d_req || force_i)) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    assign port_stall = !reset && ((i_req && !i_gnt) || (d_req && !d_gnt));

    always_comb begin
        sram_en    = i_gnt | d_gnt;
        sram_wen   = WEN_NONE;
        sram_addr  = '0;
        sram_wdata = '0;
        if (d_gnt) begin
            sram_wen   = d_wen;
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
        end else if (i_gnt) begin
            sram_addr  = i_addr;
        end
    end

    // Owner of next cycle's SRAM read data; writes return nothing.
    always_comb begin
        state_next = IDLE;
        if (i_gnt) begin
            state_next = WAIT_I;
        end else if (d_gnt && (d_wen == WEN_NONE)) begin
            state_next = WAIT_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = '0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        case (state_reg)
            WAIT_I: begin
                i_rvalid = 1'b1;
                i_rdata  = sram_rdata;
            end
            WAIT_D: begin
                d_rvalid = 1'b1;
                d_rdata  = sram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed-vector bench for sram_port_arbiter with hand-computed expectations.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        port_stall;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
    ) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .port_stall(port_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Move to just after the next rising edge, where new inputs are applied.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        i_req      = 1'b1;
        d_req      = 1'b1;
        i_addr     = 32'h0;
        d_addr     = 32'h0;
        d_wen      = 4'b0000;
        d_wdata    = 32'h0;
        sram_rdata = 32'h0;

        // Reset held with both requests pending: everything quiet.
        repeat (2) @(negedge clk);
        chk("rst_i_gnt", 64'(i_gnt), 64'd0);
        chk("rst_d_gnt", 64'(d_gnt), 64'd0);
        chk("rst_stall", 64'(port_stall), 64'd0);
        chk("rst_sram_en", 64'(sram_en), 64'd0);
        chk("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
        chk("rst_sram_addr", 64'(sram_addr), 64'd0);

        reset = 1'b0;
        #1;
        chk("rel_d_gnt", 64'(d_gnt), 64'd1);
        chk("rel_i_gnt", 64'(i_gnt), 64'd0);

        next_cycle();
        i_req = 1'b0; d_req = 1'b0; sram_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("rel_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("rel_d_rdata", 64'(d_rdata), 64'h1111_1111);

        // Fetch only.
        next_cycle();
        i_req = 1'b1; i_addr = 32'hBFC0_0000;
        @(negedge clk);
        chk("f_i_gnt", 64'(i_gnt), 64'd1);
        chk("f_sram_addr", 64'(sram_addr), 64'hBFC0_0000);
        chk("f_sram_wen", 64'(sram_wen), 64'd0);
        chk("f_sram_wdata", 64'(sram_wdata), 64'd0);
        chk("f_stall", 64'(port_stall), 64'd0);
        next_cycle();
        i_req = 1'b0; sram_rdata = 32'h3C01_0000;
        @(negedge clk);
        chk("f_i_rvalid", 64'(i_rvalid), 64'd1);
        chk("f_i_rdata", 64'(i_rdata), 64'h3C01_0000);
        chk("f_d_rvalid", 64'(d_rvalid), 64'd0);
        chk("f_d_rdata", 64'(d_rdata), 64'd0);

        // Conflict: data read wins, fetch stalls.
        next_cycle();
        i_req = 1'b1; i_addr = 32'h0000_0040;
        d_req = 1'b1; d_wen = 4'b0000; d_addr = 32'h0000_1000;
        @(negedge clk);
        chk("c_d_gnt", 64'(d_gnt), 64'd1);
        chk("c_i_gnt", 64'(i_gnt), 64'd0);
        chk("c_stall", 64'(port_stall), 64'd1);
        chk("c_sram_addr", 64'(sram_addr), 64'h0000_1000);
        next_cycle();
        i_req = 1'b0; d_req = 1'b0; sram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("c_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("c_i_rvalid", 64'(i_rvalid), 64'd0);
        chk("c_d_rdata", 64'(d_rdata), 64'h1234_5678);

        // Starvation: both held for 10 cycles, expect D,D,D,D,I,D,D,D,D,I.
        next_cycle();
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("s%0d_i_gnt", k), 64'(i_gnt), 64'((k == 4 || k == 9) ? 1 : 0));
            chk($sformatf("s%0d_d_gnt", k), 64'(d_gnt), 64'((k == 4 || k == 9) ? 0 : 1));
            chk($sformatf("s%0d_cnt", k), 64'(u_dut.u_starve.cnt_reg), 64'(k % 5));
            if (k < 9) next_cycle();
        end
        next_cycle();
        i_req = 1'b0; d_req = 1'b0;

        // Store: byte lanes and data pass through, no read return.
        next_cycle();
        d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h0000_0020; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("w_d_gnt", 64'(d_gnt), 64'd1);
        chk("w_sram_wen", 64'(sram_wen), 64'b0011);
        chk("w_sram_wdata", 64'(sram_wdata), 64'hDEAD_BEEF);
        chk("w_sram_addr", 64'(sram_addr), 64'h0000_0020);
        next_cycle();
        d_req = 1'b0; d_wen = 4'b0000; sram_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("w_d_rvalid", 64'(d_rvalid), 64'd0);
        chk("w_i_rvalid", 64'(i_rvalid), 64'd0);
        chk("w_idle_en", 64'(sram_en), 64'd0);

        // Back-to-back fetch reads: response and new grant in one cycle.
        next_cycle();
        i_req = 1'b1; i_addr = 32'h0000_0100;
        next_cycle();
        i_addr = 32'h0000_0104; sram_rdata = 32'hAAAA_0001;
        @(negedge clk);
        chk("b_i_gnt", 64'(i_gnt), 64'd1);
        chk("b_i_rvalid", 64'(i_rvalid), 64'd1);
        chk("b_i_rdata", 64'(i_rdata), 64'hAAAA_0001);
        next_cycle();
        i_req = 1'b0; sram_rdata = 32'hBBBB_0002;
        @(negedge clk);
        chk("b2_i_rvalid", 64'(i_rvalid), 64'd1);
        chk("b2_i_rdata", 64'(i_rdata), 64'hBBBB_0002);

        // Reset mid-read: outstanding fetch return is dropped at once.
        next_cycle();
        i_req = 1'b1; i_addr = 32'h0000_0200;
        @(negedge clk);
        chk("r_i_gnt", 64'(i_gnt), 64'd1);
        next_cycle();
        i_req = 1'b0; sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("r_pre_rvalid", 64'(i_rvalid), 64'd1);
        reset = 1'b1;
        #1;
        chk("r_i_rvalid", 64'(i_rvalid), 64'd0);
        chk("r_i_rdata", 64'(i_rdata), 64'd0);
        chk("r_state", 64'(u_dut.state_reg), 64'd0);
        @(negedge clk);
        chk("r_hold_rvalid", 64'(i_rvalid), 64'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported synchronous SRAM between two requesters: the instruction-fetch path and the load/store data path.
- Used for the unified-memory build of the 5-stage MIPS core, where inst and data traffic go to one RAM.
- Grants one access per cycle. Data has priority, with an anti-starvation counter that guarantees fetch progress.
- Tracks the one-cycle read latency and routes each returned word to the requester that issued the read.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data wins over a pending fetch before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch read request.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch read data valid (one-cycle pulse).
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request.
- d_wen  in  4  byte write enables; 0 means read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid (one-cycle pulse).
- d_rdata  out  DATA_W  load data.
- sram_en  out  1  SRAM enable.
- sram_wen  out  4  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after the read enable.
- port_stall  out  1  high when any request is pending but not granted this cycle; consumed by the pipeline stall logic.

Behaviour:
- Grant is combinational, in the same cycle as the request. An access is accepted when req and gnt are both high. At most one of i_gnt and d_gnt is high in any cycle.
- Arbitration:
  - Only one request pending: that requester is granted.
  - Both pending: d wins unless starve_cnt == STARVE_MAX, in which case i wins.
- starve_cnt (4-bit register):
  - Increments by 1 on each cycle where d_gnt is high and i_req is high.
  - Clears to 0 on any cycle with i_gnt or with i_req low.
  - Saturates at STARVE_MAX and never wraps.
- SRAM drive:
  - sram_en = i_gnt | d_gnt.
  - With d_gnt: sram_addr/sram_wen/sram_wdata = d_addr/d_wen/d_wdata.
  - With i_gnt: sram_addr = i_addr, sram_wen = 0, sram_wdata = 0.
  - With no grant: all SRAM outputs are 0.
- Response owner FSM (register), states IDLE, WAIT_I, WAIT_D. The next state is computed every cycle from the current grant:
  - i_gnt -> WAIT_I.
  - d_gnt with d_wen == 0 -> WAIT_D.
  - Otherwise (write, or no grant) -> IDLE.
- Outputs per state:
  - WAIT_I: i_rvalid = 1, i_rdata = sram_rdata.
  - WAIT_D: d_rvalid = 1, d_rdata = sram_rdata.
  - In the other state and in IDLE, the rvalid is 0 and the rdata is 0.
- Latency: read data appears exactly 1 cycle after the grant. Back-to-back reads are accepted every cycle with no bubble; a response and a new grant can occur in the same cycle.
- Writes complete in the grant cycle and produce no rvalid.
- Reset:
  - Asserting reset forces the owner FSM to IDLE and starve_cnt to 0 immediately.
  - A read outstanding at reset produces no rvalid.
  - While reset is high, all grants, rvalids and sram_en are 0, and port_stall is 0.
- Reset values: every output is 0.

Decomposition:
- Shared package cpu_mem_pkg:
  - owner-state encoding (IDLE=2'd0, WAIT_I=2'd1, WAIT_D=2'd2);
  - byte-enable constant WEN_NONE=4'b0000.
- One natural sub-module: arb_starve_counter, the saturating counter plus force-inst compare. Parameterized by STARVE_MAX.
- Grant mux and owner FSM stay in the top.

Test Plan:
- Reset: hold reset with i_req=d_req=1 -> all outputs 0. Release -> d_gnt=1 on the first cycle.
- Fetch only: i_req=1, i_addr=0xBFC00000 -> i_gnt=1, sram_addr=0xBFC00000 same cycle. sram_rdata=0x3C010000 next cycle -> i_rvalid=1, i_rdata=0x3C010000, d_rvalid=0.
- Conflict: i_req=d_req=1, d_wen=0, d_addr=0x00001000 -> d_gnt=1, i_gnt=0, port_stall=1. Next cycle d_rvalid=1, i_rvalid=0.
- Starvation, STARVE_MAX=4: both requests held high for 10 cycles -> grant order D,D,D,D,I,D,D,D,D,I. starve_cnt reads 0,1,2,3,4,0,...
- Store: d_req=1, d_wen=4'b0011, d_wdata=0xDEADBEEF -> sram_wen=4'b0011, sram_wdata=0xDEADBEEF. No d_rvalid the next cycle.
- Reset mid-read: i_gnt in cycle N, reset asserted asynchronously during cycle N+1 before the edge -> i_rvalid=0 immediately, FSM in IDLE.
